// File: rtl/nn_param_streamer.sv
// Byte-serial transmitter for the neuron network load interface: a word goes out MSB first with a one-hot FIFO clock-enable.
// Optional checksum cycle after each word is enabled by defining NN_STREAM_CHECKSUM_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word in flight, s_ready high
// SEND  | presenting byte idx_q of the current word
// CHK   | presenting XOR of the word's bytes (NN_STREAM_CHECKSUM_EN only)
module nn_param_streamer #(
  parameter int WORD_BITS = 32,
  parameter int N_TARGETS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_BITS-1:0] s_data,
  input  logic [2:0]           s_target,
  input  logic                 pause,
  output logic [7:0]           byte_out,
  output logic [N_TARGETS-1:0] byte_ce,
  output logic                 byte_last,
  output logic                 err_target,
  output logic                 busy
`ifdef NN_STREAM_CHECKSUM_EN
  ,
  output logic                 chk_valid
`endif
);

  localparam int NBYTES = WORD_BITS / 8;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

`ifdef NN_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [N_TARGETS-1:0]   mask_q, mask_d;
  logic [N_TARGETS-1:0]   tgt_onehot;
  logic [N_TARGETS-1:0]   ce_d;
  logic [7:0]             out_d;
  logic                   last_d;
  logic                   err_d;
  logic                   accept;
`ifdef NN_STREAM_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  // An out-of-range target decodes to all zeros, which doubles as the error flag.
  always_comb begin
    tgt_onehot = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      tgt_onehot[i] = (s_target == 3'(i));
    end
  end

`ifdef NN_STREAM_CHECKSUM_EN
  assign s_ready   = (state_q == IDLE) || (state_q == CHK);
  assign chk_valid = (state_q == CHK);
`else
  assign s_ready = (state_q == IDLE) ||
                   ((state_q == SEND) && (idx_q == IDX_LAST) && !pause);
`endif

  assign accept = s_valid && s_ready;
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    mask_d  = mask_q;
    out_d   = byte_out;
    ce_d    = '0;
    last_d  = 1'b0;
    err_d   = 1'b0;
`ifdef NN_STREAM_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
      out_d   = s_data[WORD_BITS-1 -: 8];
      shift_d = s_data << 8;
      mask_d  = tgt_onehot;
      ce_d    = tgt_onehot;
      last_d  = (NBYTES == 1);
      err_d   = ~|tgt_onehot;
`ifdef NN_STREAM_CHECKSUM_EN
      xor_d   = s_data[WORD_BITS-1 -: 8];
`endif
    end else begin
      case (state_q)
        SEND: begin
          if (idx_q == IDX_LAST) begin
`ifdef NN_STREAM_CHECKSUM_EN
            state_d = CHK;
            out_d   = xor_q;
`else
            state_d = IDLE;
`endif
          end else if (!pause) begin
            // A paused edge leaves idx/byte_out alone; the held byte was already consumed.
            idx_d   = idx_q + IDX_ONE;
            out_d   = shift_q[WORD_BITS-1 -: 8];
            shift_d = shift_q << 8;
            ce_d    = mask_q;
            last_d  = ((idx_q + IDX_ONE) == IDX_LAST);
`ifdef NN_STREAM_CHECKSUM_EN
            xor_d   = xor_q ^ shift_q[WORD_BITS-1 -: 8];
`endif
          end
        end
`ifdef NN_STREAM_CHECKSUM_EN
        CHK: state_d = IDLE;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      mask_q     <= '0;
      byte_out   <= '0;
      byte_ce    <= '0;
      byte_last  <= 1'b0;
      err_target <= 1'b0;
`ifdef NN_STREAM_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      mask_q     <= mask_d;
      byte_out   <= out_d;
      byte_ce    <= ce_d;
      byte_last  <= last_d;
      err_target <= err_d;
`ifdef NN_STREAM_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

endmodule
